// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller for the M stage: decodes IO-space accesses, buffers TX/RX bytes
// in FIFOs, drives the UART ready/valid handshakes and exposes a free-running cycle counter.
module uart_mmio_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [3:0]  IO_NIBBLE  = 4'h8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        mem_valid_m,
  input  logic        is_load_m,
  input  logic        is_store_m,
  input  logic [31:0] addr_m,
  input  logic [7:0]  wdata_m,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(FIFO_DEPTH);

  localparam logic [7:0] OffStatus = 8'h00;
  localparam logic [7:0] OffRxData = 8'h04;
  localparam logic [7:0] OffTxData = 8'h08;
  localparam logic [7:0] OffCycles = 8'h10;

  // TX FIFO state
  logic [7:0]      txMem [FIFO_DEPTH];
  logic [PtrW-1:0] txWrPtr;
  logic [PtrW-1:0] txRdPtr;
  logic [CntW-1:0] txCount;
  logic            txOvf;

  // RX FIFO state
  logic [7:0]      rxMem [FIFO_DEPTH];
  logic [PtrW-1:0] rxWrPtr;
  logic [PtrW-1:0] rxRdPtr;
  logic [CntW-1:0] rxCount;

  logic [31:0] cycleCount;

  logic       acc;
  logic       cpuLoad;
  logic       cpuStore;
  logic [7:0] offset;
  logic       txFull;
  logic       txEmpty;
  logic       rxFull;
  logic       rxEmpty;
  logic       txPushReq;
  logic       txPush;
  logic       txPop;
  logic       txOvfSet;
  logic       txOvfClear;
  logic       rxPush;
  logic       rxPop;
  logic       cycleClear;
  logic       unusedAddr;

  assign unusedAddr = ^addr_m[27:8];

  // Decode
  assign io_sel   = (addr_m[31:28] == IO_NIBBLE);
  assign acc      = mem_valid_m & io_sel & ~stall;
  assign offset   = addr_m[7:0];
  assign cpuLoad  = acc & is_load_m;
  // A simultaneous load flag wins; the store half is dropped.
  assign cpuStore = acc & is_store_m & ~is_load_m;

  // Full/empty come from the registered counts only, so same-cycle UART activity never
  // rescues a CPU push into a full TX FIFO.
  assign txFull  = (txCount == FullCount);
  assign txEmpty = (txCount == '0);
  assign rxFull  = (rxCount == FullCount);
  assign rxEmpty = (rxCount == '0);

  assign txPushReq  = cpuStore & (offset == OffTxData);
  assign txPush     = txPushReq & ~txFull;
  assign txOvfSet   = txPushReq & txFull;
  assign txOvfClear = cpuStore & (offset == OffStatus);
  assign cycleClear = cpuStore & (offset == OffCycles);
  assign rxPop      = cpuLoad & (offset == OffRxData) & ~rxEmpty;

  // UART side
  assign tx_valid = ~txEmpty;
  assign tx_data  = txMem[txRdPtr];
  assign txPop    = tx_valid & tx_ready;
  assign rx_ready = ~rxFull;
  assign rxPush   = rx_valid & rx_ready;

  // Load data mux, zero latency
  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      unique case (offset)
        OffStatus: io_rdata = {29'b0, txOvf, ~txFull, ~rxEmpty};
        OffRxData: io_rdata = rxEmpty ? 32'b0 : {24'b0, rxMem[rxRdPtr]};
        OffCycles: io_rdata = cycleCount;
        default:   io_rdata = '0;
      endcase
    end
  end

  // FIFO storage carries no reset; only pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (txPush) txMem[txWrPtr] <= wdata_m;
    if (rxPush) rxMem[rxWrPtr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txWrPtr <= '0;
      txRdPtr <= '0;
      txCount <= '0;
      txOvf   <= 1'b0;
    end else begin
      if (txPush) txWrPtr <= txWrPtr + PtrW'(1);
      if (txPop)  txRdPtr <= txRdPtr + PtrW'(1);
      unique case ({txPush, txPop})
        2'b10:   txCount <= txCount + CntW'(1);
        2'b01:   txCount <= txCount - CntW'(1);
        default: txCount <= txCount;
      endcase
      if (txOvfSet)        txOvf <= 1'b1;
      else if (txOvfClear) txOvf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxWrPtr <= '0;
      rxRdPtr <= '0;
      rxCount <= '0;
    end else begin
      if (rxPush) rxWrPtr <= rxWrPtr + PtrW'(1);
      if (rxPop)  rxRdPtr <= rxRdPtr + PtrW'(1);
      unique case ({rxPush, rxPop})
        2'b10:   rxCount <= rxCount + CntW'(1);
        2'b01:   rxCount <= rxCount - CntW'(1);
        default: rxCount <= rxCount;
      endcase
    end
  end

  // Clear beats increment; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset || cycleClear) cycleCount <= '0;
    else                     cycleCount <= cycleCount + 32'd1;
  end

endmodule
